// File: rtl/mc_cpu_control_pkg.sv
// mc_cpu_control_pkg: shared encodings for the multicycle control FSM, its datapath and bench
// Contents: state codes, ALU op codes, mux select codes, opcode values,
//           Moore control bundle and the per-state control decode.
package mc_cpu_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD, S_MEM_WR, S_WB_ALU,
        S_WB_MEM, S_BRANCH, S_JAL, S_JALR, S_LUI, S_AUIPC, S_TRAP
    } state_t;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                        ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
                        ALU_SRL = 4'd8, ALU_SRA = 4'd9;

    localparam logic [1:0] PCSRC_ALU = 2'd0, PCSRC_ALUOUT = 2'd1, PCSRC_TRAP = 2'd2;
    localparam logic [1:0] SRCA_PC = 2'd0, SRCA_RS1 = 2'd1, SRCA_ZERO = 2'd2;
    localparam logic [1:0] SRCB_RS2 = 2'd0, SRCB_IMM = 2'd1, SRCB_FOUR = 2'd2;
    localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4;
    localparam logic [1:0] M2R_ALUOUT = 2'd0, M2R_MDR = 2'd1, M2R_PC = 2'd2;

    localparam logic [4:0] OP_LOAD = 5'b00000, OP_I = 5'b00100, OP_AUIPC = 5'b00101,
                           OP_STORE = 5'b01000, OP_R = 5'b01100, OP_LUI = 5'b01101,
                           OP_BR = 5'b11000, OP_JALR = 5'b11001, OP_JAL = 5'b11011;

    typedef struct packed {
        logic       cpu_mio;
        logic       mem_rw;
        logic       iord;
        logic       reg_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [2:0] imm_sel;
        logic [1:0] mem_to_reg;
    } ctl_t;

    function automatic state_t dispatch(input logic [4:0] op);
        case (op)
            OP_R:              return S_EXEC_R;
            OP_I:              return S_EXEC_I;
            OP_LOAD, OP_STORE: return S_MEM_ADDR;
            OP_BR:             return S_BRANCH;
            OP_JAL:            return S_JAL;
            OP_JALR:           return S_JALR;
            OP_LUI:            return S_LUI;
            OP_AUIPC:          return S_AUIPC;
            default:           return S_TRAP;
        endcase
    endfunction

    function automatic ctl_t ctl_of(input state_t s, input logic store);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH:    begin c.cpu_mio = 1'b1; c.src_b = SRCB_FOUR; end
            S_DECODE:   begin c.src_b = SRCB_IMM; c.imm_sel = IMM_B; end
            S_EXEC_R:   c.src_a = SRCA_RS1;
            S_EXEC_I:   begin c.src_a = SRCA_RS1; c.src_b = SRCB_IMM; end
            S_MEM_ADDR: begin c.src_a = SRCA_RS1; c.src_b = SRCB_IMM; c.imm_sel = store ? IMM_S : IMM_I; end
            S_MEM_RD:   begin c.cpu_mio = 1'b1; c.iord = 1'b1; end
            S_MEM_WR:   begin c.cpu_mio = 1'b1; c.iord = 1'b1; c.mem_rw = 1'b1; end
            S_WB_ALU:   c.reg_write = 1'b1;
            S_WB_MEM:   begin c.reg_write = 1'b1; c.mem_to_reg = M2R_MDR; end
            S_BRANCH:   begin c.src_a = SRCA_RS1; c.pc_src = PCSRC_ALUOUT; c.imm_sel = IMM_B; end
            S_JAL:      begin c.reg_write = 1'b1; c.pc_write = 1'b1; c.mem_to_reg = M2R_PC; c.pc_src = PCSRC_ALUOUT; c.src_b = SRCB_IMM; c.imm_sel = IMM_J; end
            S_JALR:     begin c.reg_write = 1'b1; c.pc_write = 1'b1; c.mem_to_reg = M2R_PC; c.src_a = SRCA_RS1; c.src_b = SRCB_IMM; end
            S_LUI:      begin c.reg_write = 1'b1; c.src_a = SRCA_ZERO; c.src_b = SRCB_IMM; c.imm_sel = IMM_U; end
            S_AUIPC:    begin c.reg_write = 1'b1; c.src_b = SRCB_IMM; c.imm_sel = IMM_U; end
            S_TRAP:     begin c.pc_write = 1'b1; c.pc_src = PCSRC_TRAP; end
            default:    c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// mc_alu_decode: maps OPcode/Fun3/Fun7 to the ALU operation for R, I and branch instructions
// Ports: opcode (inst[6:2]), fun3 (inst[14:12]), fun7 (inst[30]) in; alu_op out (add for everything else).
module mc_alu_decode
    import mc_cpu_control_pkg::*;
(
    input  logic [4:0] opcode,
    input  logic [2:0] fun3,
    input  logic       fun7,
    output logic [3:0] alu_op
);
    alu_op_t arith;

    // Fun7 selects sub only for R-type; for I-type it only distinguishes srai from srli.
    always_comb begin
        arith = ALU_ADD;
        case (fun3)
            3'b000:  arith = ((opcode == OP_R) & fun7) ? ALU_SUB : ALU_ADD;
            3'b001:  arith = ALU_SLL;
            3'b010:  arith = ALU_SLT;
            3'b011:  arith = ALU_SLTU;
            3'b100:  arith = ALU_XOR;
            3'b101:  arith = fun7 ? ALU_SRA : ALU_SRL;
            3'b110:  arith = ALU_OR;
            default: arith = ALU_AND;
        endcase
    end

    // Branches compare: beq/bne subtract, blt/bge slt, bltu/bgeu sltu.
    assign alu_op = (opcode == OP_R || opcode == OP_I) ? arith
                  : (opcode == OP_BR) ? (fun3[2] ? (fun3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB)
                  : ALU_ADD;
endmodule

// File: rtl/mc_cpu_control.sv
// mc_cpu_control: multicycle RV32 control FSM with memory wait timeout and sticky fault flags
// Inputs:  clk, rst (async, active-high), inst (IR), MIO_ready, br_cond.
// Outputs: memory handshake (CPU_MIO, MemRW, IorD), write enables (IRWrite, PCWrite, RegWrite),
//          mux selects (PCSrc, ALUSrc_A, ALUSrc_B, ImmSel, MemtoReg), ALU_Control,
//          sticky faults (illegal_inst, bus_err) and the debug state code.
module mc_cpu_control
    import mc_cpu_control_pkg::*;
#(
    parameter int ALU_W       = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst,
    input  logic             MIO_ready,
    input  logic             br_cond,
    output logic             CPU_MIO,
    output logic             MemRW,
    output logic             IorD,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic [1:0]       PCSrc,
    output logic [1:0]       ALUSrc_A,
    output logic [1:0]       ALUSrc_B,
    output logic [2:0]       ImmSel,
    output logic [ALU_W-1:0] ALU_Control,
    output logic [1:0]       MemtoReg,
    output logic             illegal_inst,
    output logic             bus_err,
    output logic [3:0]       state
);
    state_t     st, nxt;
    ctl_t       ctl;
    logic [7:0] cnt;
    logic [3:0] dec_op;
    logic       mem_st, done, tmo;
    logic       unused;

    mc_alu_decode u_dec (
        .opcode (inst[6:2]),
        .fun3   (inst[14:12]),
        .fun7   (inst[30]),
        .alu_op (dec_op)
    );

    assign unused = ^{inst[31], inst[29:15], inst[11:7], inst[1:0]};

    // A memory cycle only counts while the registered request is actually out, so
    // MIO_ready is ignored in the dead cycle after reset release.
    assign mem_st = (st == S_FETCH) | (st == S_MEM_RD) | (st == S_MEM_WR);
    assign done   = mem_st & ctl.cpu_mio & MIO_ready;
    assign tmo    = mem_st & ctl.cpu_mio & ~MIO_ready & (cnt == 8'(MEM_TIMEOUT - 1));

    always_comb begin
        nxt = st;
        case (st)
            S_FETCH, S_MEM_RD, S_MEM_WR:
                nxt = tmo ? S_TRAP : ~done ? st : (st == S_FETCH) ? S_DECODE : (st == S_MEM_RD) ? S_WB_MEM : S_FETCH;
            S_DECODE:           nxt = dispatch(inst[6:2]);
            S_EXEC_R, S_EXEC_I: nxt = S_WB_ALU;
            S_MEM_ADDR:         nxt = inst[5] ? S_MEM_WR : S_MEM_RD;
            default:            nxt = S_FETCH;
        endcase
    end

    // Moore controls are registered from the next state, so they change on the same edge as
    // the state and are forced low asynchronously by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st           <= S_FETCH;
            cnt          <= '0;
            ctl          <= '0;
            ALU_Control  <= '0;
            illegal_inst <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            st           <= nxt;
            cnt          <= (mem_st & ctl.cpu_mio & ~MIO_ready & ~tmo) ? cnt + 8'd1 : 8'd0;
            ctl          <= ctl_of(nxt, inst[5]);
            ALU_Control  <= ALU_W'((nxt == S_EXEC_R || nxt == S_EXEC_I || nxt == S_BRANCH) ? dec_op : ALU_ADD);
            illegal_inst <= illegal_inst | ((st == S_DECODE) & (nxt == S_TRAP));
            bus_err      <= bus_err | tmo;
        end
    end

    // Fun3[0] inverts the branch sense (bne/bge/bgeu).
    assign IRWrite  = (st == S_FETCH) & done;
    assign PCWrite  = IRWrite | ((st == S_BRANCH) & (br_cond ^ inst[12])) | ctl.pc_write;
    assign CPU_MIO  = ctl.cpu_mio;
    assign MemRW    = ctl.mem_rw;
    assign IorD     = ctl.iord;
    assign RegWrite = ctl.reg_write;
    assign PCSrc    = ctl.pc_src;
    assign ALUSrc_A = ctl.src_a;
    assign ALUSrc_B = ctl.src_b;
    assign ImmSel   = ctl.imm_sel;
    assign MemtoReg = ctl.mem_to_reg;
    assign state    = st;
endmodule

// File: tb/tb_mc_cpu_control.sv
// tb_mc_cpu_control: directed self-checking bench for mc_cpu_control
module tb_mc_cpu_control;
    import mc_cpu_control_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] inst = '0;
    logic        MIO_ready = 1'b0;
    logic        br_cond = 1'b0;
    logic        CPU_MIO, MemRW, IorD, IRWrite, PCWrite, RegWrite, illegal_inst, bus_err;
    logic [1:0]  PCSrc, ALUSrc_A, ALUSrc_B, MemtoReg;
    logic [2:0]  ImmSel;
    logic [3:0]  ALU_Control, state;
    int          tests = 0;
    int          fails = 0;

    mc_cpu_control #(.ALU_W(4), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .inst(inst), .MIO_ready(MIO_ready), .br_cond(br_cond),
        .CPU_MIO(CPU_MIO), .MemRW(MemRW), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .RegWrite(RegWrite), .PCSrc(PCSrc), .ALUSrc_A(ALUSrc_A), .ALUSrc_B(ALUSrc_B),
        .ImmSel(ImmSel), .ALU_Control(ALU_Control), .MemtoReg(MemtoReg),
        .illegal_inst(illegal_inst), .bus_err(bus_err), .state(state)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [2:0] f3, input logic f7);
        return {1'b0, f7, 15'b0, f3, 5'b0, op, 2'b11};
    endfunction

    task automatic reset_dut();
        rst = 1'b1; MIO_ready = 1'b0; br_cond = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Fetch (ready at once) and decode; returns 1 ns after the negedge of the first execute state.
    task automatic issue(input logic [31:0] w);
        @(negedge clk); inst = w; MIO_ready = 1'b1; #1;
        @(negedge clk); MIO_ready = 1'b0; #1;
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1; #2;
        tests++; if ({state, CPU_MIO, PCWrite, IRWrite, RegWrite, illegal_inst, bus_err} !== {S_FETCH, 6'b0}) begin fails++; $display("FAIL reset_async: got %h exp %h", {state, CPU_MIO, PCWrite, IRWrite, RegWrite, illegal_inst, bus_err}, {S_FETCH, 6'b0}); end
        MIO_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        tests++; if ({state, CPU_MIO, IRWrite, PCWrite} !== {S_FETCH, 3'b0}) begin fails++; $display("FAIL reset_held: got %h exp %h", {state, CPU_MIO, IRWrite, PCWrite}, {S_FETCH, 3'b0}); end
        rst = 1'b0; #1;
        tests++; if (CPU_MIO !== 1'b0) begin fails++; $display("FAIL release_no_req: CPU_MIO got %b exp 0", CPU_MIO); end
        @(posedge clk); #1;
        tests++; if ({state, CPU_MIO, IorD, MemRW} !== {S_FETCH, 3'b100}) begin fails++; $display("FAIL first_fetch: got %h exp %h", {state, CPU_MIO, IorD, MemRW}, {S_FETCH, 3'b100}); end
        MIO_ready = 1'b0;
    endtask

    task automatic test_add();
        @(negedge clk); inst = 32'h002081B3; MIO_ready = 1'b1; #1;
        tests++; if ({IRWrite, PCWrite, ALUSrc_A, ALUSrc_B, ALU_Control} !== {2'b11, SRCA_PC, SRCB_FOUR, ALU_ADD}) begin fails++; $display("FAIL add_fetch: got %h exp %h", {IRWrite, PCWrite, ALUSrc_A, ALUSrc_B, ALU_Control}, {2'b11, SRCA_PC, SRCB_FOUR, ALU_ADD}); end
        @(negedge clk); MIO_ready = 1'b0; #1;
        tests++; if ({state, CPU_MIO, IRWrite, ALUSrc_B, ImmSel} !== {S_DECODE, 2'b00, SRCB_IMM, IMM_B}) begin fails++; $display("FAIL add_decode: got %h exp %h", {state, CPU_MIO, IRWrite, ALUSrc_B, ImmSel}, {S_DECODE, 2'b00, SRCB_IMM, IMM_B}); end
        @(negedge clk); #1;
        tests++; if ({state, ALU_Control, ALUSrc_A, ALUSrc_B, RegWrite} !== {S_EXEC_R, ALU_ADD, SRCA_RS1, SRCB_RS2, 1'b0}) begin fails++; $display("FAIL add_exec: got %h exp %h", {state, ALU_Control, ALUSrc_A, ALUSrc_B, RegWrite}, {S_EXEC_R, ALU_ADD, SRCA_RS1, SRCB_RS2, 1'b0}); end
        @(negedge clk); #1;
        tests++; if ({state, RegWrite, MemtoReg} !== {S_WB_ALU, 1'b1, M2R_ALUOUT}) begin fails++; $display("FAIL add_wb: got %h exp %h", {state, RegWrite, MemtoReg}, {S_WB_ALU, 1'b1, M2R_ALUOUT}); end
        @(negedge clk); #1;
        tests++; if ({state, RegWrite, CPU_MIO} !== {S_FETCH, 2'b01}) begin fails++; $display("FAIL add_done: got %h exp %h", {state, RegWrite, CPU_MIO}, {S_FETCH, 2'b01}); end
    endtask

    task automatic test_alu_ops();
        logic [4:0] op [6] = '{OP_R,     OP_R,     OP_I,     OP_I,     OP_I,     OP_R};
        logic [2:0] f3 [6] = '{3'b000,   3'b101,   3'b000,   3'b101,   3'b101,   3'b111};
        logic       f7 [6] = '{1'b1,     1'b1,     1'b1,     1'b1,     1'b0,     1'b0};
        alu_op_t    ex [6] = '{ALU_SUB,  ALU_SRA,  ALU_ADD,  ALU_SRA,  ALU_SRL,  ALU_AND};
        state_t     es [6] = '{S_EXEC_R, S_EXEC_R, S_EXEC_I, S_EXEC_I, S_EXEC_I, S_EXEC_R};
        for (int i = 0; i < 6; i++) begin
            issue(mk(op[i], f3[i], f7[i]));
            tests++; if ({state, ALU_Control} !== {es[i], ex[i]}) begin fails++; $display("FAIL alu_op[%0d]: got %h exp %h", i, {state, ALU_Control}, {es[i], ex[i]}); end
            @(negedge clk); #1;
            @(negedge clk); #1;
        end
    endtask

    task automatic test_lw();
        int hi = 0;
        issue(32'h0000A183);
        tests++; if ({state, ALUSrc_A, ALUSrc_B, ImmSel} !== {S_MEM_ADDR, SRCA_RS1, SRCB_IMM, IMM_I}) begin fails++; $display("FAIL lw_addr: got %h exp %h", {state, ALUSrc_A, ALUSrc_B, ImmSel}, {S_MEM_ADDR, SRCA_RS1, SRCB_IMM, IMM_I}); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); MIO_ready = (i == 3); #1;
            if (CPU_MIO && IorD && !MemRW && state == S_MEM_RD) hi++;
        end
        tests++; if (hi !== 4) begin fails++; $display("FAIL lw_req_cycles: got %0d exp 4", hi); end
        @(negedge clk); MIO_ready = 1'b0; #1;
        tests++; if ({state, RegWrite, MemtoReg, CPU_MIO} !== {S_WB_MEM, 1'b1, M2R_MDR, 1'b0}) begin fails++; $display("FAIL lw_wb: got %h exp %h", {state, RegWrite, MemtoReg, CPU_MIO}, {S_WB_MEM, 1'b1, M2R_MDR, 1'b0}); end
        @(negedge clk); #1;
        tests++; if ({state, RegWrite, CPU_MIO, IorD} !== {S_FETCH, 3'b010}) begin fails++; $display("FAIL lw_done: got %h exp %h", {state, RegWrite, CPU_MIO, IorD}, {S_FETCH, 3'b010}); end
    endtask

    task automatic test_branch();
        issue(mk(OP_BR, 3'b001, 1'b0));
        br_cond = 1'b1; #1;
        tests++; if ({state, PCWrite, ALU_Control} !== {S_BRANCH, 1'b0, ALU_SUB}) begin fails++; $display("FAIL bne_taken_eq: got %h exp %h", {state, PCWrite, ALU_Control}, {S_BRANCH, 1'b0, ALU_SUB}); end
        br_cond = 1'b0; #1;
        tests++; if ({PCWrite, PCSrc} !== {1'b1, PCSRC_ALUOUT}) begin fails++; $display("FAIL bne_ne: got %h exp %h", {PCWrite, PCSrc}, {1'b1, PCSRC_ALUOUT}); end
        @(negedge clk); #1;
        tests++; if ({state, PCWrite} !== {S_FETCH, 1'b0}) begin fails++; $display("FAIL bne_done: got %h exp %h", {state, PCWrite}, {S_FETCH, 1'b0}); end
        issue(mk(OP_BR, 3'b000, 1'b0));
        br_cond = 1'b1; #1;
        tests++; if (PCWrite !== 1'b1) begin fails++; $display("FAIL beq_eq: PCWrite got %b exp 1", PCWrite); end
        br_cond = 1'b0; #1;
        tests++; if (PCWrite !== 1'b0) begin fails++; $display("FAIL beq_ne: PCWrite got %b exp 0", PCWrite); end
        @(negedge clk); #1;
        issue(mk(OP_BR, 3'b110, 1'b0));
        tests++; if ({state, ALU_Control} !== {S_BRANCH, ALU_SLTU}) begin fails++; $display("FAIL bltu_op: got %h exp %h", {state, ALU_Control}, {S_BRANCH, ALU_SLTU}); end
        @(negedge clk); #1;
    endtask

    task automatic test_jump_upper();
        issue(mk(OP_JAL, 3'b000, 1'b0));
        tests++; if ({state, RegWrite, MemtoReg, PCWrite, PCSrc, ImmSel} !== {S_JAL, 1'b1, M2R_PC, 1'b1, PCSRC_ALUOUT, IMM_J}) begin fails++; $display("FAIL jal: got %h exp %h", {state, RegWrite, MemtoReg, PCWrite, PCSrc, ImmSel}, {S_JAL, 1'b1, M2R_PC, 1'b1, PCSRC_ALUOUT, IMM_J}); end
        @(negedge clk); #1;
        tests++; if ({state, RegWrite, PCWrite} !== {S_FETCH, 2'b00}) begin fails++; $display("FAIL jal_done: got %h exp %h", {state, RegWrite, PCWrite}, {S_FETCH, 2'b00}); end
        issue(mk(OP_JALR, 3'b000, 1'b0));
        tests++; if ({state, PCSrc, PCWrite, ALUSrc_A, ALUSrc_B, MemtoReg} !== {S_JALR, PCSRC_ALU, 1'b1, SRCA_RS1, SRCB_IMM, M2R_PC}) begin fails++; $display("FAIL jalr: got %h exp %h", {state, PCSrc, PCWrite, ALUSrc_A, ALUSrc_B, MemtoReg}, {S_JALR, PCSRC_ALU, 1'b1, SRCA_RS1, SRCB_IMM, M2R_PC}); end
        @(negedge clk); #1;
        issue(mk(OP_LUI, 3'b000, 1'b0));
        tests++; if ({state, ALUSrc_A, ALUSrc_B, ImmSel, RegWrite} !== {S_LUI, SRCA_ZERO, SRCB_IMM, IMM_U, 1'b1}) begin fails++; $display("FAIL lui: got %h exp %h", {state, ALUSrc_A, ALUSrc_B, ImmSel, RegWrite}, {S_LUI, SRCA_ZERO, SRCB_IMM, IMM_U, 1'b1}); end
        @(negedge clk); #1;
        issue(mk(OP_AUIPC, 3'b000, 1'b0));
        tests++; if ({state, ALUSrc_A, ImmSel, RegWrite} !== {S_AUIPC, SRCA_PC, IMM_U, 1'b1}) begin fails++; $display("FAIL auipc: got %h exp %h", {state, ALUSrc_A, ImmSel, RegWrite}, {S_AUIPC, SRCA_PC, IMM_U, 1'b1}); end
        @(negedge clk); #1;
    endtask

    task automatic test_timeout();
        reset_dut();
        inst = 32'h002081B3;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk); MIO_ready = 1'b0; #1;
            if (i == 15) begin
                tests++; if ({state, CPU_MIO, bus_err} !== {S_FETCH, 2'b10}) begin fails++; $display("FAIL tmo_last_wait: got %h exp %h", {state, CPU_MIO, bus_err}, {S_FETCH, 2'b10}); end
            end
        end
        @(negedge clk); #1;
        tests++; if ({state, bus_err, CPU_MIO, PCWrite, PCSrc} !== {S_TRAP, 3'b101, PCSRC_TRAP}) begin fails++; $display("FAIL tmo_trap: got %h exp %h", {state, bus_err, CPU_MIO, PCWrite, PCSrc}, {S_TRAP, 3'b101, PCSRC_TRAP}); end
        @(negedge clk); #1;
        tests++; if ({state, bus_err, PCWrite, PCSrc, illegal_inst} !== {S_FETCH, 2'b10, PCSRC_ALU, 1'b0}) begin fails++; $display("FAIL tmo_sticky: got %h exp %h", {state, bus_err, PCWrite, PCSrc, illegal_inst}, {S_FETCH, 2'b10, PCSRC_ALU, 1'b0}); end
    endtask

    task automatic test_ready_on_last();
        reset_dut();
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk); MIO_ready = (i == 15); #1;
        end
        tests++; if ({IRWrite, bus_err} !== 2'b10) begin fails++; $display("FAIL ready15_accept: got %b exp 10", {IRWrite, bus_err}); end
        @(negedge clk); MIO_ready = 1'b0; #1;
        tests++; if ({state, bus_err} !== {S_DECODE, 1'b0}) begin fails++; $display("FAIL ready15_no_err: got %h exp %h", {state, bus_err}, {S_DECODE, 1'b0}); end
        @(negedge clk); #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
    endtask

    task automatic test_illegal();
        reset_dut();
        issue(32'hFFFFFFFF);
        tests++; if ({state, illegal_inst, PCWrite, PCSrc} !== {S_TRAP, 2'b11, PCSRC_TRAP}) begin fails++; $display("FAIL ill_trap: got %h exp %h", {state, illegal_inst, PCWrite, PCSrc}, {S_TRAP, 2'b11, PCSRC_TRAP}); end
        @(negedge clk); #1;
        tests++; if ({state, illegal_inst, PCWrite, PCSrc, CPU_MIO} !== {S_FETCH, 2'b10, PCSRC_ALU, 1'b1}) begin fails++; $display("FAIL ill_after: got %h exp %h", {state, illegal_inst, PCWrite, PCSrc, CPU_MIO}, {S_FETCH, 2'b10, PCSRC_ALU, 1'b1}); end
    endtask

    task automatic test_rst_mid_wr();
        issue(mk(OP_STORE, 3'b010, 1'b0));
        tests++; if ({state, ImmSel} !== {S_MEM_ADDR, IMM_S}) begin fails++; $display("FAIL sw_addr: got %h exp %h", {state, ImmSel}, {S_MEM_ADDR, IMM_S}); end
        @(negedge clk); #1;
        tests++; if ({state, CPU_MIO, MemRW, IorD, illegal_inst} !== {S_MEM_WR, 4'b1111}) begin fails++; $display("FAIL sw_req: got %h exp %h", {state, CPU_MIO, MemRW, IorD, illegal_inst}, {S_MEM_WR, 4'b1111}); end
        rst = 1'b1; #1;
        tests++; if ({state, CPU_MIO, MemRW, illegal_inst, bus_err, PCWrite, RegWrite} !== {S_FETCH, 6'b0}) begin fails++; $display("FAIL rst_mid_wr: got %h exp %h", {state, CPU_MIO, MemRW, illegal_inst, bus_err, PCWrite, RegWrite}, {S_FETCH, 6'b0}); end
        @(negedge clk); rst = 1'b0; #1;
        tests++; if (CPU_MIO !== 1'b0) begin fails++; $display("FAIL rst_release_gap: CPU_MIO got %b exp 0", CPU_MIO); end
        @(posedge clk); #1;
        tests++; if ({state, CPU_MIO, MemRW} !== {S_FETCH, 2'b10}) begin fails++; $display("FAIL rst_refetch: got %h exp %h", {state, CPU_MIO, MemRW}, {S_FETCH, 2'b10}); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu_ops();
        test_lw();
        test_branch();
        test_jump_upper();
        test_timeout();
        test_ready_on_last();
        test_illegal();
        test_rst_mid_wr();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
